axil_uart_regs: RTL and testbench

AXI4-Lite slave register block that terminates the AXI4-Lite bus and drives the UART core. It decodes four 32-bit registers (TXDATA, RXDATA, STATUS, CTRL) and pushes bytes to the UART transmitter. It pops bytes from the UART receiver and exports the baud divisor. It sits between the bus interface (4-bit address, 32-bit data) and the UART TX/RX engines.

---
 rtl/axil_uart_pkg.sv | 32 +++
 rtl/axil_uart_regs.sv | 222 ++++++++++++++++++++++
 tb/tb_axil_uart_regs.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_uart_pkg.sv
// axil_uart_pkg: shared constants for the AXI4-Lite UART register block.
// Holds the register offsets (decoded from ADDR[3:2]), the AXI response
// codes, the STATUS/RXDATA bit positions and a byte-lane merge helper.
package axil_uart_pkg;

  typedef enum logic [1:0] {
    ADDR_TXDATA = 2'd0,
    ADDR_RXDATA = 2'd1,
    ADDR_STATUS = 2'd2,
    ADDR_CTRL   = 2'd3
  } reg_addr_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STAT_TX_READY_BIT = 0;
  localparam int STAT_RX_VALID_BIT = 1;
  localparam int STAT_TX_BUSY_BIT  = 2;
  localparam int STAT_OVERRUN_BIT  = 3;
  localparam int RXDATA_EMPTY_BIT  = 31;

  // Replace the byte lanes of a 16-bit register that are enabled in strb.
  function automatic logic [15:0] merge_bytes16(input logic [15:0] cur,
                                                input logic [15:0] wdat,
                                                input logic [1:0]  strb);
    logic [15:0] res;
    res[7:0]  = strb[0] ? wdat[7:0]  : cur[7:0];
    res[15:8] = strb[1] ? wdat[15:8] : cur[15:8];
    return res;
  endfunction

endpackage

// File: rtl/axil_uart_regs.sv
// axil_uart_regs: AXI4-Lite slave exposing TXDATA/RXDATA/STATUS/CTRL.
// Ports:
//   ACLK, ARESETN         clock, async active-low reset
//   AW*/W*/B*             write address/data/response channels
//   AR*/R*                read address/data channels
//   tx_data/tx_valid      push strobe into the UART TX FIFO (tx_ready, tx_busy in)
//   rx_data/rx_valid      head of UART RX FIFO; rx_ready is the pop strobe
//   rx_overrun            RX overflow pulse, latched into STATUS[3]
//   baud_div              divisor to the baud generator (CTRL[15:0])
module axil_uart_regs
  import axil_uart_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 4,
  parameter int          DATA_WIDTH  = 32,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic                    tx_busy,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  input  logic                    rx_overrun,
  output logic [15:0]             baud_div
);

  logic        rst_done_r;
  logic        aw_full_r;
  reg_addr_e   aw_addr_r;
  logic        w_full_r;
  logic [15:0] w_data_r;
  logic [1:0]  w_strb_r;
  logic        bvalid_r;
  logic [1:0]  bresp_r;
  logic        rvalid_r;
  logic [31:0] rdata_r;
  logic [1:0]  rresp_r;
  logic [15:0] baud_div_r;
  logic        overrun_r;

  logic        aw_ready_s, w_ready_s, ar_ready_s;
  logic        aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  reg_addr_e   wr_addr_s, rd_addr_s;
  logic [15:0] wr_data_s;
  logic [1:0]  wr_strb_s;
  logic [1:0]  wr_resp_s;
  logic        tx_push_s, ctrl_we_s, rx_pop_s;
  logic [31:0] rd_data_s;
  logic        unused_s;

  // Byte offset bits and upper data/strobe lanes carry no register state.
  assign unused_s = ^{AWADDR[1:0], ARADDR[1:0], WDATA[DATA_WIDTH-1:16], WSTRB[DATA_WIDTH/8-1:2]};

  // A full slot keeps its own ready low; a pending response blocks both.
  assign aw_ready_s = rst_done_r & ~aw_full_r & ~bvalid_r;
  assign w_ready_s  = rst_done_r & ~w_full_r & ~bvalid_r;
  assign ar_ready_s = rst_done_r & ~rvalid_r;
  assign aw_hs_s    = AWVALID & aw_ready_s;
  assign w_hs_s     = WVALID & w_ready_s;
  assign ar_hs_s    = ARVALID & ar_ready_s;

  // Commit as soon as address and data are both available (held or live).
  assign commit_s  = (aw_full_r | aw_hs_s) & (w_full_r | w_hs_s);
  assign wr_addr_s = aw_full_r ? aw_addr_r : reg_addr_e'(AWADDR[3:2]);
  assign wr_data_s = w_full_r ? w_data_r : WDATA[15:0];
  assign wr_strb_s = w_full_r ? w_strb_r : WSTRB[1:0];
  assign rd_addr_s = reg_addr_e'(ARADDR[3:2]);

  // Tracks the first clock after reset release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rst_done_r <= 1'b0;
    else          rst_done_r <= 1'b1;
  end

  // Decodes the committing write into side effects and a response code.
  always_comb begin
    wr_resp_s = RESP_OKAY;
    tx_push_s = 1'b0;
    ctrl_we_s = 1'b0;
    if (commit_s) begin
      case (wr_addr_s)
        ADDR_TXDATA: begin
          if (wr_strb_s[0]) begin
            if (tx_ready) tx_push_s = 1'b1;
            else          wr_resp_s = RESP_SLVERR;
          end else begin
            wr_resp_s = RESP_OKAY;
          end
        end
        ADDR_CTRL: ctrl_we_s = 1'b1;
        default:   wr_resp_s = RESP_SLVERR;
      endcase
    end else begin
      wr_resp_s = RESP_OKAY;
    end
  end

  // Holds whichever of AW/W arrives first until its partner shows up.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full_r <= 1'b0;
      aw_addr_r <= ADDR_TXDATA;
      w_full_r  <= 1'b0;
      w_data_r  <= 16'h0000;
      w_strb_r  <= 2'b00;
    end else if (commit_s) begin
      aw_full_r <= 1'b0;
      w_full_r  <= 1'b0;
    end else begin
      if (aw_hs_s) begin
        aw_full_r <= 1'b1;
        aw_addr_r <= reg_addr_e'(AWADDR[3:2]);
      end
      if (w_hs_s) begin
        w_full_r <= 1'b1;
        w_data_r <= WDATA[15:0];
        w_strb_r <= WSTRB[1:0];
      end
    end
  end

  // Raises BVALID on commit and holds it until the master takes it.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bvalid_r <= 1'b0;
      bresp_r  <= RESP_OKAY;
    end else if (commit_s) begin
      bvalid_r <= 1'b1;
      bresp_r  <= wr_resp_s;
    end else if (bvalid_r && BREADY) begin
      bvalid_r <= 1'b0;
    end
  end

  // Baud divisor register, byte-lane writable through CTRL.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)       baud_div_r <= DEFAULT_DIV;
    else if (ctrl_we_s) baud_div_r <= merge_bytes16(baud_div_r, wr_data_s, wr_strb_s);
  end

  // Builds read data from the live inputs; RXDATA pops only on a non-empty FIFO.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    rx_pop_s  = 1'b0;
    case (rd_addr_s)
      ADDR_TXDATA: rd_data_s = 32'h0000_0000;
      ADDR_RXDATA: begin
        if (rx_valid) begin
          rd_data_s[7:0] = rx_data;
          rx_pop_s       = ar_hs_s;
        end else begin
          rd_data_s[RXDATA_EMPTY_BIT] = 1'b1;
        end
      end
      ADDR_STATUS: begin
        rd_data_s[STAT_TX_READY_BIT] = tx_ready;
        rd_data_s[STAT_RX_VALID_BIT] = rx_valid;
        rd_data_s[STAT_TX_BUSY_BIT]  = tx_busy;
        // A pulse in the read cycle is reported right away.
        rd_data_s[STAT_OVERRUN_BIT]  = overrun_r | rx_overrun;
      end
      ADDR_CTRL: rd_data_s[15:0] = baud_div_r;
      default:   rd_data_s = 32'h0000_0000;
    endcase
  end

  // Registers the read response on AR handshake; holds until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      rresp_r  <= RESP_OKAY;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_data_s;
      rresp_r  <= RESP_OKAY;
    end else if (rvalid_r && RREADY) begin
      rvalid_r <= 1'b0;
    end
  end

  // Sticky overrun flag: a new pulse beats the STATUS read clear.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                                overrun_r <= 1'b0;
    else if (rx_overrun)                         overrun_r <= 1'b1;
    else if (ar_hs_s && rd_addr_s == ADDR_STATUS) overrun_r <= 1'b0;
  end

  assign AWREADY  = aw_ready_s;
  assign WREADY   = w_ready_s;
  assign ARREADY  = ar_ready_s;
  assign BVALID   = bvalid_r;
  assign BRESP    = bresp_r;
  assign RVALID   = rvalid_r;
  assign RDATA    = rdata_r;
  assign RRESP    = rresp_r;
  assign tx_valid = tx_push_s;
  assign tx_data  = tx_push_s ? wr_data_s[7:0] : 8'h00;
  assign rx_ready = rx_pop_s;
  assign baud_div = baud_div_r;

endmodule

// File: tb/tb_axil_uart_regs.sv
// tb_axil_uart_regs: directed checks of the documented scenarios followed by
// randomized register traffic compared against a register-level model.
module tb_axil_uart_regs;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_overrun;
  logic [15:0] baud_div;

  axil_uart_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
    .baud_div(baud_div)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe monitor, sampled mid-cycle.
  int         tx_cnt  = 0;
  logic [7:0] tx_last = 8'h00;
  int         tx_bad  = 0;
  int         pop_cnt = 0;
  always @(negedge ACLK) begin
    if (tx_valid === 1'b1) begin
      tx_cnt++;
      tx_last = tx_data;
      if (tx_ready !== 1'b1) tx_bad++;
    end
    if (rx_ready === 1'b1) pop_cnt++;
  end

  // Register-level model state.
  logic [15:0] m_baud = 16'd868;
  bit          m_ovr  = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // skew > 0: AW leads W by skew cycles; skew < 0: W leads AW.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int skew, output logic [1:0] resp);
    int aw_at, w_at, t, lat;
    bit aw_done, w_done;
    aw_at = (skew < 0) ? -skew : 0;
    w_at  = (skew > 0) ? skew : 0;
    aw_done = 1'b0; w_done = 1'b0; t = 0;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    while (!(aw_done && w_done) && t < 50) begin
      AWVALID = (!aw_done && (t >= aw_at));
      WVALID  = (!w_done && (t >= w_at));
      @(negedge ACLK);
      if (aw_done) check("aw_held_ready", 32'(AWREADY), 32'd0);
      if (w_done)  check("w_held_ready", 32'(WREADY), 32'd0);
      if (AWVALID && AWREADY) aw_done = 1'b1;
      if (WVALID && WREADY)   w_done  = 1'b1;
      @(posedge ACLK); #1;
      t++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    if (!(aw_done && w_done)) check("wr_hs_timeout", 32'd1, 32'd0);
    BREADY = 1'b1; lat = 0;
    @(negedge ACLK);
    while (!BVALID && lat < 20) begin
      @(negedge ACLK);
      lat++;
    end
    check("b_latency", lat, 32'd0);
    resp = BRESP;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
  endtask

  // ovr_pulse drives rx_overrun in the AR handshake cycle.
  task automatic do_read(input logic [3:0] addr, input bit ovr_pulse,
                         output logic [31:0] data, output logic [1:0] resp);
    int t, lat;
    bit done;
    ARADDR = addr; ARVALID = 1'b1; rx_overrun = ovr_pulse; done = 1'b0; t = 0;
    while (!done && t < 20) begin
      @(negedge ACLK);
      if (ARREADY) done = 1'b1;
      @(posedge ACLK); #1;
      rx_overrun = 1'b0;
      t++;
    end
    ARVALID = 1'b0;
    if (!done) check("ar_timeout", 32'd1, 32'd0);
    RREADY = 1'b1; lat = 0;
    @(negedge ACLK);
    while (!RVALID && lat < 20) begin
      @(negedge ACLK);
      lat++;
    end
    check("r_latency", lat, 32'd0);
    data = RDATA; resp = RRESP;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    int          tx0, pop0;

    ARESETN = 1'b0; AWADDR = 4'h0; AWVALID = 1'b0; WDATA = 32'h0; WSTRB = 4'h0;
    WVALID = 1'b0; BREADY = 1'b0; ARADDR = 4'h0; ARVALID = 1'b0; RREADY = 1'b0;
    tx_ready = 1'b1; tx_busy = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_overrun = 1'b0;

    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", 32'(AWREADY), 32'd0);
    check("rst_wready", 32'(WREADY), 32'd0);
    check("rst_arready", 32'(ARREADY), 32'd0);
    check("rst_bvalid", 32'(BVALID), 32'd0);
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_baud", 32'(baud_div), 32'd868);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("awready_before_rst_done", 32'(AWREADY), 32'd0);
    @(posedge ACLK); #1;

    do_read(4'hC, 1'b0, rd, rs);
    check("ctrl_reset_rd", rd, 32'h0000_0364);
    check("ctrl_reset_rresp", 32'(rs), 32'd0);
    do_read(4'h8, 1'b0, rd, rs);
    check("status_reset_rd", rd, 32'h0000_0001);

    // AW three cycles ahead of W; push happens in the W cycle
    tx0 = tx_cnt;
    AWADDR = 4'h0; AWVALID = 1'b1;
    @(negedge ACLK);
    check("t_awready", 32'(AWREADY), 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    repeat (2) begin
      @(negedge ACLK);
      check("t_aw_slot_held", 32'(AWREADY), 32'd0);
      check("t_no_early_push", 32'(tx_valid), 32'd0);
      @(posedge ACLK); #1;
    end
    WDATA = 32'h0000_0041; WSTRB = 4'h1; WVALID = 1'b1;
    @(negedge ACLK);
    check("t_wready", 32'(WREADY), 32'd1);
    check("t_tx_valid", 32'(tx_valid), 32'd1);
    check("t_tx_data", 32'(tx_data), 32'h41);
    check("t_bvalid_early", 32'(BVALID), 32'd0);
    @(posedge ACLK); #1;
    WVALID = 1'b0; BREADY = 1'b1;
    @(negedge ACLK);
    check("t_bvalid", 32'(BVALID), 32'd1);
    check("t_bresp", 32'(BRESP), 32'd0);
    check("t_tx_valid_off", 32'(tx_valid), 32'd0);
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    check("t_push_count", tx_cnt - tx0, 32'd1);

    // TX FIFO full, and writes to read-only registers
    tx_ready = 1'b0; tx0 = tx_cnt;
    do_write(4'h0, 32'h0000_0055, 4'hF, 0, rs);
    check("txfull_bresp", 32'(rs), 32'h2);
    check("txfull_no_push", tx_cnt - tx0, 32'd0);
    tx_ready = 1'b1;
    do_write(4'h8, 32'hFFFF_FFFF, 4'hF, 1, rs);
    check("status_wr_bresp", 32'(rs), 32'h2);
    do_read(4'h8, 1'b0, rd, rs);
    check("status_unchanged", rd, 32'h0000_0001);

    // Partial CTRL write
    do_write(4'hC, 32'h1234_5678, 4'h1, -2, rs);
    m_baud = 16'h0378;
    check("ctrl_bresp", 32'(rs), 32'd0);
    check("ctrl_baud", 32'(baud_div), 32'h0378);
    do_read(4'hC, 1'b0, rd, rs);
    check("ctrl_readback", rd, 32'h0000_0378);

    // RX pops
    rx_valid = 1'b1; rx_data = 8'h5A; pop0 = pop_cnt;
    do_read(4'h4, 1'b0, rd, rs);
    check("rx_data", rd, 32'h0000_005A);
    check("rx_pop_once", pop_cnt - pop0, 32'd1);
    rx_valid = 1'b0; pop0 = pop_cnt;
    do_read(4'h4, 1'b0, rd, rs);
    check("rx_empty", rd, 32'h8000_0000);
    check("rx_no_pop", pop_cnt - pop0, 32'd0);

    // Overrun pulse coincident with the clearing read
    do_read(4'h8, 1'b1, rd, rs);
    check("ovr_coincident", rd, 32'h0000_0009);
    do_read(4'h8, 1'b0, rd, rs);
    check("ovr_set_wins", rd, 32'h0000_0009);
    do_read(4'h8, 1'b0, rd, rs);
    check("ovr_cleared", rd, 32'h0000_0001);

    // Simultaneous write and read with responses back-pressured
    AWADDR = 4'hC; WDATA = 32'h0000_ABCD; WSTRB = 4'h3; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 4'hC; ARVALID = 1'b1;
    @(negedge ACLK);
    check("bp_accept", {29'd0, AWREADY, WREADY, ARREADY}, 32'h7);
    @(posedge ACLK); #1;
    WDATA = 32'h0000_1111;
    repeat (5) begin
      @(negedge ACLK);
      check("bp_bvalid", 32'(BVALID), 32'd1);
      check("bp_bresp", 32'(BRESP), 32'd0);
      check("bp_rvalid", 32'(RVALID), 32'd1);
      check("bp_rdata", RDATA, 32'h0000_0378);
      check("bp_blocked", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
      @(posedge ACLK); #1;
    end
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0; RREADY = 1'b0;
    m_baud = 16'hABCD;
    @(negedge ACLK);
    check("bp_drained", {30'd0, BVALID, RVALID}, 32'd0);
    check("bp_baud", 32'(baud_div), 32'hABCD);
    @(posedge ACLK); #1;

    // Reset with an address held: the slot must be discarded
    tx0 = tx_cnt;
    AWADDR = 4'h0; AWVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; ARESETN = 1'b0;
    @(negedge ACLK);
    check("mid_rst_ready", {30'd0, AWREADY, BVALID}, 32'd0);
    check("mid_rst_baud", 32'(baud_div), 32'd868);
    @(posedge ACLK); #1;
    ARESETN = 1'b1; m_baud = 16'd868; m_ovr = 1'b0;
    @(posedge ACLK); #1;
    WDATA = 32'h0000_0077; WSTRB = 4'h1; WVALID = 1'b1;
    @(negedge ACLK);
    check("mid_rst_wready", 32'(WREADY), 32'd1);
    check("mid_rst_no_push", 32'(tx_valid), 32'd0);
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    repeat (2) begin
      @(negedge ACLK);
      check("mid_rst_no_b", 32'(BVALID), 32'd0);
      @(posedge ACLK); #1;
    end
    check("mid_rst_push_count", tx_cnt - tx0, 32'd0);
    AWADDR = 4'h0; AWVALID = 1'b1;
    @(negedge ACLK);
    check("mid_rst_late_push", {23'd0, tx_valid, tx_data}, 32'h177);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; BREADY = 1'b1;
    @(negedge ACLK);
    check("mid_rst_bvalid", 32'(BVALID), 32'd1);
    @(posedge ACLK); #1;
    BREADY = 1'b0;

    // Randomized traffic against the register model
    for (int i = 0; i < 80; i++) begin
      logic [3:0]  a;
      logic [31:0] d, exp_d;
      logic [3:0]  s;
      logic [1:0]  exp_r;
      int          sk, exp_push;
      bit          ovp;
      tx_ready = ($urandom_range(0, 3) != 0);
      tx_busy  = 1'($urandom_range(0, 1));
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        rx_overrun = 1'b1;
        @(posedge ACLK); #1;
        rx_overrun = 1'b0;
        m_ovr = 1'b1;
      end
      a = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom); sk = $urandom_range(0, 6) - 3;
        exp_r = 2'b00; exp_push = 0;
        case (a[3:2])
          2'd0: begin
            if (s[0] && tx_ready) exp_push = 1;
            else if (s[0])        exp_r = 2'b10;
            else                  exp_r = 2'b00;
          end
          2'd3: begin
            if (s[0]) m_baud[7:0]  = d[7:0];
            if (s[1]) m_baud[15:8] = d[15:8];
          end
          default: exp_r = 2'b10;
        endcase
        tx0 = tx_cnt;
        do_write(a, d, s, sk, rs);
        check("rnd_bresp", 32'(rs), 32'(exp_r));
        check("rnd_pushes", tx_cnt - tx0, exp_push);
        if (exp_push == 1) check("rnd_tx_byte", 32'(tx_last), 32'(d[7:0]));
        check("rnd_baud", 32'(baud_div), 32'(m_baud));
      end else begin
        ovp = ($urandom_range(0, 5) == 0);
        exp_push = 0;
        case (a[3:2])
          2'd0: exp_d = 32'h0;
          2'd1: begin
            exp_d = rx_valid ? {24'h0, rx_data} : 32'h8000_0000;
            exp_push = rx_valid ? 1 : 0;
          end
          2'd2: exp_d = {28'h0, (m_ovr | ovp), tx_busy, rx_valid, tx_ready};
          default: exp_d = {16'h0, m_baud};
        endcase
        if (a[3:2] == 2'd2) m_ovr = ovp;
        else                m_ovr = m_ovr | ovp;
        pop0 = pop_cnt;
        do_read(a, ovp, rd, rs);
        check("rnd_rdata", rd, exp_d);
        check("rnd_rresp", 32'(rs), 32'd0);
        check("rnd_pops", pop_cnt - pop0, exp_push);
      end
    end

    check("tx_valid_without_ready", tx_bad, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
